// File: rtl/odd_parity_pkg.sv
// Shared definitions for the odd-parity generator/receiver pair: receiver
// state encoding, the parity sense and a counter-width helper.
package odd_parity_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam logic ODD = 1'b1;

  // Never returns less than 1 so a one-bit data word still gets a legal counter.
  function automatic int clog2(input int n);
    int r;
    r = 1;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/odd_parity_calc.sv
// Combinational odd-parity check: ok_o is high when data plus parity bit
// carry an odd number of ones. Usable by the generator side as well.
module odd_parity_calc
  import odd_parity_pkg::*;
#(
  parameter int DATA_W = 3
) (
  input  logic [DATA_W-1:0] data_i,
  input  logic              pbit_i,
  output logic              ok_o
);

  assign ok_o = (((^data_i) ^ pbit_i) == ODD);

endmodule

// File: rtl/odd_parity_serial_rx.sv
// Serial receiver for start/data(LSB first)/odd-parity/stop frames, presenting
// each word with parity and framing status over a valid/ready handshake.
module odd_parity_serial_rx
  import odd_parity_pkg::*;
#(
  parameter int DATA_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_en,
  input  logic              sin,
  output logic [DATA_W-1:0] data_out,
  output logic              valid,
  input  logic              ready,
  output logic              parity_err,
  output logic              frame_err,
  output logic              overrun
);

  localparam int CNT_W = clog2(DATA_W);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DATA_W - 1);

  rx_state_t         state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              pbit_q, pbit_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              valid_q, valid_d;
  logic              perr_q, perr_d;
  logic              ferr_q, ferr_d;
  logic              ovr_q, ovr_d;

  logic [DATA_W-1:0] shifted;
  logic              parityOk;
  logic              accept;
  logic              frameDone;

  // New bits enter at the MSB so the first (LSB) bit ends up in bit 0.
  if (DATA_W == 1) begin : g_shift1
    assign shifted = sin;
  end else begin : g_shiftN
    assign shifted = {sin, shreg_q[DATA_W-1:1]};
  end

  odd_parity_calc #(.DATA_W(DATA_W)) u_calc (
    .data_i (shreg_q),
    .pbit_i (pbit_q),
    .ok_o   (parityOk)
  );

  // ready is only honoured on strobe cycles, like sin.
  assign accept = valid_q && ready && bit_en;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    shreg_d   = shreg_q;
    pbit_d    = pbit_q;
    data_d    = data_q;
    valid_d   = valid_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    ovr_d     = 1'b0;
    frameDone = 1'b0;

    if (accept) valid_d = 1'b0;

    if (bit_en) begin
      case (state_q)
        IDLE: begin
          if (!sin) begin
            state_d = DATA;
            cnt_d   = '0;
          end
        end
        DATA: begin
          shreg_d = shifted;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST) state_d = PARITY;
        end
        PARITY: begin
          pbit_d  = sin;
          state_d = STOP;
        end
        STOP: begin
          state_d   = IDLE;
          frameDone = 1'b1;
        end
        default: state_d = IDLE;
      endcase
    end

    // A completing frame either refills the output slot or, if the old word is
    // still unaccepted, is dropped with an overrun pulse.
    if (frameDone) begin
      if (!valid_q || accept) begin
        data_d  = shreg_q;
        valid_d = 1'b1;
        perr_d  = ~parityOk;
        ferr_d  = ~sin;
      end else begin
        ovr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      shreg_q <= '0;
      pbit_q  <= 1'b0;
      data_q  <= '0;
      valid_q <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      shreg_q <= shreg_d;
      pbit_q  <= pbit_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      perr_q  <= perr_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign data_out   = data_q;
  assign valid      = valid_q;
  assign parity_err = perr_q;
  assign frame_err  = ferr_q;
  assign overrun    = ovr_q;

endmodule

// File: tb/tb_odd_parity_serial_rx.sv
// Self-checking bench for odd_parity_serial_rx: directed frame table, overrun,
// mid-frame reset and randomized frames against a popcount-based model.
module tb_odd_parity_serial_rx;

  localparam int DATA_W = 3;
  localparam logic [7:0] XOR_TBL = 8'b10010110;

  logic              clk;
  logic              rst;
  logic              bit_en;
  logic              sin;
  logic [DATA_W-1:0] data_out;
  logic              valid;
  logic              ready;
  logic              parity_err;
  logic              frame_err;
  logic              overrun;

  int checks = 0;
  int errors = 0;
  int gap    = 1;

  typedef struct {
    logic [DATA_W-1:0] data;
    logic              pbit;
    logic              stop;
    logic [DATA_W-1:0] expData;
    logic              expPerr;
    logic              expFerr;
  } vec_t;

  vec_t vecs[$];

  odd_parity_serial_rx #(.DATA_W(DATA_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .bit_en     (bit_en),
    .sin        (sin),
    .data_out   (data_out),
    .valid      (valid),
    .ready      (ready),
    .parity_err (parity_err),
    .frame_err  (frame_err),
    .overrun    (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // One bit strobe, preceded by gap-1 idle cycles with junk on sin.
  task automatic applyStimulus(input logic b);
    for (int k = 0; k < gap - 1; k++) begin
      bit_en = 1'b0;
      sin    = 1'($urandom);
      @(posedge clk);
      #1;
    end
    bit_en = 1'b1;
    sin    = b;
    @(posedge clk);
    #1;
    bit_en = 1'b0;
    sin    = 1'b1;
  endtask

  task automatic sendFrame(input logic [DATA_W-1:0] d, input logic p, input logic s,
                           input logic checkIdle);
    applyStimulus(1'b0);
    for (int i = 0; i < DATA_W; i++) applyStimulus(d[i]);
    applyStimulus(p);
    if (checkIdle) checkOutput("valid_before_stop", 32'(valid), 32'd0);
    applyStimulus(s);
  endtask

  function automatic logic genBit(input logic [DATA_W-1:0] d);
    return ~XOR_TBL[d];
  endfunction

  initial begin
    rst    = 1'b1;
    bit_en = 1'b0;
    sin    = 1'b1;
    ready  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_valid", 32'(valid), 32'd0);
    checkOutput("reset_data", 32'(data_out), 32'd0);
    checkOutput("reset_perr", 32'(parity_err), 32'd0);
    checkOutput("reset_ferr", 32'(frame_err), 32'd0);
    checkOutput("reset_ovr", 32'(overrun), 32'd0);
    rst = 1'b0;

    vecs.push_back('{3'b101, 1'b1, 1'b1, 3'b101, 1'b0, 1'b0});
    vecs.push_back('{3'b011, 1'b0, 1'b1, 3'b011, 1'b1, 1'b0});
    vecs.push_back('{3'b011, 1'b1, 1'b1, 3'b011, 1'b0, 1'b0});
    for (int w = 0; w < 8; w++) begin
      vecs.push_back('{3'(w), genBit(3'(w)), 1'b1, 3'(w), 1'b0, 1'b0});
    end
    vecs.push_back('{3'b110, 1'b1, 1'b0, 3'b110, 1'b0, 1'b1});
    vecs.push_back('{3'b001, 1'b0, 1'b1, 3'b001, 1'b0, 1'b0});

    for (int m = 0; m < 2; m++) begin
      gap = (m == 0) ? 1 : 4;
      foreach (vecs[i]) begin
        sendFrame(vecs[i].data, vecs[i].pbit, vecs[i].stop, 1'b1);
        checkOutput("tbl_valid", 32'(valid), 32'd1);
        checkOutput("tbl_data", 32'(data_out), 32'(vecs[i].expData));
        checkOutput("tbl_perr", 32'(parity_err), 32'(vecs[i].expPerr));
        checkOutput("tbl_ferr", 32'(frame_err), 32'(vecs[i].expFerr));
        checkOutput("tbl_ovr", 32'(overrun), 32'd0);
      end
    end

    // Overrun: second frame arrives while the first is still held.
    gap = 1;
    applyStimulus(1'b1);
    applyStimulus(1'b1);
    checkOutput("ovr_pre_valid", 32'(valid), 32'd0);
    ready = 1'b0;
    sendFrame(3'b100, 1'b0, 1'b1, 1'b1);
    checkOutput("ovr_a_valid", 32'(valid), 32'd1);
    checkOutput("ovr_a_data", 32'(data_out), 32'd4);
    checkOutput("ovr_a_pulse", 32'(overrun), 32'd0);
    sendFrame(3'b011, 1'b1, 1'b1, 1'b0);
    checkOutput("ovr_b_valid", 32'(valid), 32'd1);
    checkOutput("ovr_b_data", 32'(data_out), 32'd4);
    checkOutput("ovr_b_perr", 32'(parity_err), 32'd0);
    checkOutput("ovr_b_pulse", 32'(overrun), 32'd1);
    @(posedge clk);
    #1;
    checkOutput("ovr_pulse_end", 32'(overrun), 32'd0);
    checkOutput("ovr_hold_valid", 32'(valid), 32'd1);
    ready = 1'b1;
    applyStimulus(1'b1);
    checkOutput("ovr_drop_valid", 32'(valid), 32'd0);

    // Reset during the second data bit aborts the frame.
    applyStimulus(1'b0);
    applyStimulus(1'b1);
    rst    = 1'b1;
    bit_en = 1'b1;
    sin    = 1'b0;
    @(posedge clk);
    #1;
    rst    = 1'b0;
    bit_en = 1'b0;
    sin    = 1'b1;
    checkOutput("rst_data", 32'(data_out), 32'd0);
    for (int k = 0; k < 6; k++) begin
      applyStimulus(1'b1);
      checkOutput("rst_no_valid", 32'(valid), 32'd0);
    end
    sendFrame(3'b010, genBit(3'b010), 1'b1, 1'b1);
    checkOutput("rst_next_valid", 32'(valid), 32'd1);
    checkOutput("rst_next_data", 32'(data_out), 32'd2);
    checkOutput("rst_next_perr", 32'(parity_err), 32'd0);

    // Randomized frames against a popcount model.
    for (int n = 0; n < 40; n++) begin
      logic [DATA_W-1:0] d;
      logic              p;
      logic              s;
      int                idle;
      d    = DATA_W'($urandom);
      p    = 1'($urandom);
      s    = ($urandom_range(0, 3) != 0);
      gap  = ($urandom_range(0, 1) == 0) ? 1 : 4;
      idle = $urandom_range(0, 2);
      for (int k = 0; k < idle; k++) applyStimulus(1'b1);
      sendFrame(d, p, s, 1'b1);
      checkOutput("rnd_valid", 32'(valid), 32'd1);
      checkOutput("rnd_data", 32'(data_out), 32'(d));
      checkOutput("rnd_perr", 32'(parity_err), 32'((($countones(d) + int'(p)) % 2) == 0));
      checkOutput("rnd_ferr", 32'(frame_err), 32'(!s));
      checkOutput("rnd_ovr", 32'(overrun), 32'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
